// File: rtl/count_seg_display.sv
// Two-digit time-multiplexed 7-segment driver for a sampled 4-bit counter value.
// Optional DISPLAY_HEX_EN: show the value as one hex digit with the tens slot blank.
module count_seg_display #(
  parameter int CLK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  input  logic       count_valid,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {UNITS, TENS} slot_t;

  slot_t            state;
  slot_t            state_next;
  logic [3:0]       held;
  logic [3:0]       units;
  logic [3:0]       tens;
  logic [3:0]       units_next;
  logic [3:0]       tens_next;
  logic [DIV_W-1:0] div;
  logic             terminal;
  logic [6:0]       seg_next;
  logic [1:0]       an_next;

  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  assign terminal = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 4'd0;
    end else if (count_valid) begin
      held <= count_in;
    end
  end

  // Digit split runs one cycle behind the capture register.
  always_comb begin
    units_next = held;
    tens_next  = 4'd0;
`ifdef DISPLAY_HEX_EN
    units_next = held;
    tens_next  = 4'd0;
`else
    if (held >= 4'd10) begin
      units_next = held - 4'd10;
      tens_next  = 4'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units <= 4'd0;
      tens  <= 4'd0;
    end else begin
      units <= units_next;
      tens  <= tens_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (terminal) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNITS;
    end else begin
      state <= state_next;
    end
  end

  // Slot sequencing plus the next registered display value.
  always_comb begin
    state_next = state;
    seg_next   = 7'h00;
    an_next    = 2'b00;
    case (state)
      UNITS: begin
        if (terminal) state_next = TENS;
        an_next  = 2'b01;
        seg_next = decode(units);
      end
      TENS: begin
        if (terminal) state_next = UNITS;
        if (tens != 4'd0) begin
          an_next  = 2'b10;
          seg_next = decode(tens);
        end
      end
      default: state_next = UNITS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h00;
      an  <= 2'b00;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: doc/count_seg_display.md
Name: count_seg_display

Overview:
- Downstream consumer of the 4-bit ripple/T-FF counter value; drives a two-digit, time-multiplexed 7-segment display.
- Samples the counter on a strobe and converts 0..15 to decimal tens/units with leading-zero blanking.
- Scans the two digits with a refresh divider; all display outputs are registered.

Parameters:
CLK_DIV, 1000, clocks per digit slot; legal range >= 2; divider width is $clog2(CLK_DIV).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
count_in  input  4  counter value to display.
count_valid  input  1  sample strobe; capture count_in on this edge.
seg  output  7  segment drives, active-high; seg[0]=a ... seg[6]=g.
an  output  2  digit enables, active-high; an[0]=units, an[1]=tens.

Behaviour:
- rst asserted, immediately and asynchronously, clears all of the following:
  - held=0, units=0, tens=0, div=0, state=UNITS, seg=7'h00, an=2'b00.
- Reset mid-slot aborts the slot. The first post-reset output appears one clock after rst deasserts.
- Capture:
  - At a rising edge with count_valid=1, held <= count_in. Otherwise held keeps its value.
  - count_valid held high captures on every edge.
- Conversion (registered, one cycle after held changes):
  - held <= 9: tens=0, units=held.
  - held >= 10: tens=1, units=held-10.
- Refresh divider:
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - At the edge where div==CLK_DIV-1, state toggles UNITS<->TENS. Each slot is exactly CLK_DIV cycles.
- FSM (two states):
  - UNITS -> TENS on the terminal count; TENS -> UNITS on the terminal count. No other transitions.
- Output register: at each edge, outputs reflect state and digit registers as sampled at that edge.
  - state==UNITS: an=2'b01, seg=decode(units).
  - state==TENS and tens!=0: an=2'b10, seg=decode(tens).
  - state==TENS and tens==0: an=2'b00, seg=7'h00 (leading-zero blank).
- Latency:
  - count_valid at edge N -> held at N -> digits at N+1 -> seg/an at N+2, if the matching slot is active.
  - State change at edge M -> seg/an change at M+1.
- Simultaneous count_valid and terminal count: both take effect at the same edge; no priority and no lost capture.
- an is never 2'b11.
- Decode, gfedcba hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71 (hex mode only).

Optional Feature:
DISPLAY_HEX_EN
- Defined:
  - units = held, shown as a single hex digit 0..F.
  - tens is forced to 0, so the tens slot is always blank (an=00, seg=00).
  - Slot timing is unchanged.
- Undefined: decimal conversion as above; hex-letter decode entries are unreachable.

Test Plan:
- Reset with CLK_DIV=4:
  - While rst=1: seg=00, an=00.
  - After release: an=01 and seg=3F one edge later.
  - an then alternates 01 / 00 every 4 cycles (tens blank).
- Capture count_in=7 for one cycle:
  - Two cycles later, in the UNITS slot: an=01, seg=07.
  - In the TENS slot: an=00, seg=00.
- Capture count_in=12:
  - UNITS slot: an=01, seg=5B.
  - TENS slot: an=10, seg=06.
  - Slot widths are exactly 4 cycles each.
- Pulse count_valid on the same edge as div==3 with count_in=15:
  - State toggles and the capture succeeds.
  - UNITS slot later shows seg=6D; TENS slot shows 06.
- Assert rst mid-TENS slot with held=12:
  - seg/an go to 00 without waiting for a clock edge.
  - After release: UNITS slot shows 3F.
- With DISPLAY_HEX_EN defined, capture count_in=12, then 15:
  - UNITS slot shows seg=39, then seg=71.
  - TENS slot always shows an=00, seg=00.
